mips_muldiv: RTL and testbench

Multi-cycle HI/LO multiply/divide unit for the single-cycle MIPS core. It sits directly downstream of instruction decode, alongside the ALU. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI/LO registers that the writeback mux reads for MFHI/MFLO. While an operation is in flight it raises `busy`, and the core stalls fetch/decode on that signal.

---
 rtl/mips_muldiv.sv | 96 +++++++++
 tb/tb_mips_muldiv.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mips_muldiv.sv
// mips_muldiv: multi-cycle HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; division is unchanged.
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH:0] rem, sum, shl, diff;
  logic [WIDTH-1:0] b, rs_abs, rt_abs, quo, rmd;
  logic neg_q, neg_r, is_div, dz, accept, sgn, rs_neg, rt_neg, mul_op, div_op;
  assign busy = state != IDLE;
  always_comb begin
    accept = start && state == IDLE;
    mul_op = op[2:1] == 2'd0;
    div_op = op[2:1] == 2'd1;
    sgn    = op == 3'd0 || op == 3'd2;
    rs_neg = sgn && rs_data[WIDTH-1];
    rt_neg = sgn && rt_data[WIDTH-1];
    rs_abs = rs_neg ? -rs_data : rs_data;
    rt_abs = rt_neg ? -rt_data : rt_data;
    // Shift-add: multiplier sits in acc's low half and shifts out LSB first.
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
    // Restoring step: dividend bits shift out of acc into the partial remainder.
    shl    = {rem[WIDTH-1:0], acc[WIDTH-1]};
    diff   = shl - {1'b0, b};
    prod   = neg_q ? -acc : acc;
    quo    = dz ? '1 : neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rmd    = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    state_n = state;
    unique case (state)
`ifdef MULDIV_FAST_MUL_EN
      IDLE: state_n = (accept && mul_op) ? FIX : (accept && div_op) ? DIV : IDLE;
`else
      IDLE: state_n = (accept && mul_op) ? MUL : (accept && div_op) ? DIV : IDLE;
`endif
      MUL, DIV: state_n = (cnt == CW'(1)) ? FIX : state;
      FIX: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= state == FIX;
      if (accept && op == 3'd4) hi <= rs_data;
      if (accept && op == 3'd5) lo <= rs_data;
      if (accept && (mul_op || div_op)) begin
        neg_q  <= rs_neg ^ rt_neg;
        neg_r  <= rs_neg;
        is_div <= div_op;
        dz     <= div_op && rt_data == '0;
        b      <= div_op ? rt_abs : rs_abs;
        rem    <= '0;
        cnt    <= CW'(WIDTH);
`ifdef MULDIV_FAST_MUL_EN
        acc    <= div_op ? {{WIDTH{1'b0}}, rs_abs}
                         : {{WIDTH{1'b0}}, rs_abs} * {{WIDTH{1'b0}}, rt_abs};
`else
        acc    <= {{WIDTH{1'b0}}, div_op ? rs_abs : rt_abs};
`endif
      end
      if (state == MUL) begin
        acc <= {sum, acc[WIDTH-1:1]};
        cnt <= cnt - CW'(1);
      end
      if (state == DIV) begin
        rem <= diff[WIDTH] ? shl : diff;
        acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~diff[WIDTH]};
        cnt <= cnt - CW'(1);
      end
      if (state == FIX) begin
        hi <= is_div ? rmd : prod[2*WIDTH-1:WIDTH];
        lo <= is_div ? quo : prod[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: table vectors, corner sequences and random ops against an arithmetic model.
module tb_mips_muldiv;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  logic clk = 0, rst_b = 0, start = 0, busy, done;
  logic [2:0] op = 0;
  logic [W-1:0] rs_data = 0, rt_data = 0, hi, lo;
  int tests = 0, fails = 0;

  mips_muldiv #(.WIDTH(W)) dut (.clk(clk), .rst_b(rst_b), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .done(done), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  typedef struct {logic [2:0] op; logic [31:0] a, b, ehi, elo; string name;} vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa = $signed(a), sb = $signed(b);
    longint unsigned ua = a, ub = b;
    case (o)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: return b == 0 ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      3'd3: return b == 0 ? {a, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
      default: return 64'd0;
    endcase
  endfunction

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input string name, input logic [63:0] exp, input bit inject);
    int n = 0;
    int lat = (o < 3'd2) ? MUL_LAT : W + 1;
    @(negedge clk);
    start = 1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 0;
    if (inject) begin
      start = 1; op = 3'd5; rs_data = 32'h1;
    end
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
      start = 0;
    end
    check({name, " latency"}, 64'(n), 64'(lat));
    check({name, " done"}, 64'(done), 64'd1);
    check({name, " hi"}, 64'(hi), 64'(exp[63:32]));
    check({name, " lo"}, 64'(lo), 64'(exp[31:0]));
    @(negedge clk);
    check({name, " done pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    vec_t v[$];
    v.push_back('{3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult -1*2"});
    v.push_back('{3'd1, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, "multu"});
    v.push_back('{3'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2"});
    v.push_back('{3'd3, 32'h7, 32'h2, 32'h1, 32'h3, "divu 7/2"});
    v.push_back('{3'd3, 32'h7, 32'h0, 32'h7, 32'hFFFF_FFFF, "divu by 0"});
    v.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div overflow"});
    v.push_back('{3'd2, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div -7 by 0"});
    v.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, "mult minint^2"});
    v.push_back('{3'd2, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, "div 7/-2"});

    repeat (2) @(negedge clk);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    rst_b = 1;

    foreach (v[i]) run(v[i].op, v[i].a, v[i].b, v[i].name, {v[i].ehi, v[i].elo}, 0);

    @(negedge clk);
    start = 1; op = 3'd4; rs_data = 32'h1234_5678;
    @(negedge clk);
    check("mthi hi", 64'(hi), 64'h1234_5678);
    check("mthi busy", 64'(busy), 64'd0);
    op = 3'd5; rs_data = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 0;
    check("mtlo lo", 64'(lo), 64'h9ABC_DEF0);
    check("mtlo hi kept", 64'(hi), 64'h1234_5678);
    check("mtlo busy", 64'(busy), 64'd0);
    check("mtlo done", 64'(done), 64'd0);

    run(3'd3, 32'd100, 32'd7, "div ignores mtlo", {32'd2, 32'd14}, 1);

    @(negedge clk);
    start = 1; op = 3'd0; rs_data = 32'hFFFF_FFFF; rt_data = 32'h2;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    rst_b = 0;
    @(negedge clk);
    rst_b = 1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset hi", 64'(hi), 64'd0);
    check("midreset lo", 64'(lo), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    repeat (W + 4) begin
      @(negedge clk);
      if (done) check("midreset late done", 64'(done), 64'd0);
    end
    check("midreset hi stays", 64'(hi), 64'd0);
    run(3'd1, 32'd3, 32'd5, "multu 3*5", 64'd15, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 3));
      a = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b = ($urandom_range(0, 6) == 0) ? 32'd0 : ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      run(o, a, b, $sformatf("rand%0d op%0d", i, o), model(o, a, b), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
